// File: rtl/load_store_unit.sv
// Load/store unit: turns one core load or store into one or two aligned
// 64-bit memory beats and returns extended load data to the core.
module load_store_unit #(
  parameter int GPR_BITS  = 64,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [2:0]           req_funct3,
  input  logic [GPR_BITS-1:0]  req_addr,
  input  logic [GPR_BITS-1:0]  req_wdata,
  output logic                 resp_valid,
  output logic [GPR_BITS-1:0]  resp_rdata,
  output logic                 resp_err,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [63:0]          mem_wdata,
  output logic [7:0]           mem_wstrb,
  input  logic                 mem_rvalid,
  input  logic [63:0]          mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BEAT0  = 3'd1,
    S_RWAIT0 = 3'd2,
    S_BEAT1  = 3'd3,
    S_RWAIT1 = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t                 state_reg;
  logic                   req_ready_reg;
  logic                   resp_valid_reg;
  logic [GPR_BITS-1:0]    resp_rdata_reg;
  logic                   resp_err_reg;
  logic                   mem_valid_reg;
  logic                   mem_we_reg;
  logic [ADDR_BITS-1:0]   mem_addr_reg;
  logic [63:0]            mem_wdata_reg;
  logic [7:0]             mem_wstrb_reg;

  // Request fields captured at accept time
  logic                   store_reg;
  logic [2:0]             funct3_reg;
  logic [2:0]             off_reg;
  logic [15:0]            mask_reg;
  logic [127:0]           wide_reg;
  logic [ADDR_BITS-1:0]   base_reg;
  logic [63:0]            rdata0_reg;

  // Decode of the incoming request
  logic [2:0]             req_off;
  logic [15:0]            req_lanes;
  logic [15:0]            req_mask;
  logic [127:0]           req_wide;
  logic [ADDR_BITS-1:0]   req_base;
  logic                   req_illegal;
  logic                   split;
  logic [ADDR_BITS-1:0]   beat1_addr;
  logic                   unused_addr_bits;

  // Address bits above the physical width are dropped
  assign unused_addr_bits = ^req_addr[GPR_BITS-1:ADDR_BITS];

  assign req_off     = req_addr[2:0];
  assign req_mask    = req_lanes << req_off;
  assign req_wide    = {64'b0, 64'(req_wdata)} << {req_off, 3'b000};
  assign req_base    = {req_addr[ADDR_BITS-1:3], 3'b000};
  assign req_illegal = (req_funct3 == 3'b111) || (req_store && req_funct3[2]);

  // The access crosses into the next dword when any upper lane is touched
  assign split      = (mask_reg[15:8] != 8'h00);
  // Second beat address wraps around the physical address space
  assign beat1_addr = base_reg + ADDR_BITS'(8);

  // Byte-lane pattern of the access size before positioning at the offset
  always_comb begin
    req_lanes = 16'h0000;
    case (req_funct3[1:0])
      2'b00:   req_lanes = 16'h0001;
      2'b01:   req_lanes = 16'h0003;
      2'b10:   req_lanes = 16'h000F;
      default: req_lanes = 16'h00FF;
    endcase
  end

  // Align the two-dword read window to the access and extend to register width
  function automatic logic [63:0] load_extend(input logic [127:0] pair,
                                              input logic [2:0]   off,
                                              input logic [2:0]   f3);
    logic [127:0] shifted;
    logic [63:0]  raw;
    logic [63:0]  res;
    shifted = pair >> {off, 3'b000};
    raw     = shifted[63:0];
    case (f3[1:0])
      2'b00:   res = f3[2] ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'b01:   res = f3[2] ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   res = f3[2] ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Main control FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      mem_valid_reg  <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_wstrb_reg  <= '0;
      store_reg      <= 1'b0;
      funct3_reg     <= '0;
      off_reg        <= '0;
      mask_reg       <= '0;
      wide_reg       <= '0;
      base_reg       <= '0;
      rdata0_reg     <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_reg <= 1'b0;
            store_reg     <= req_store;
            funct3_reg    <= req_funct3;
            off_reg       <= req_off;
            mask_reg      <= req_mask;
            wide_reg      <= req_wide;
            base_reg      <= req_base;
            if (req_illegal) begin
              state_reg      <= S_RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= '0;
            end else begin
              state_reg     <= S_BEAT0;
              resp_err_reg  <= 1'b0;
              mem_valid_reg <= 1'b1;
              mem_we_reg    <= req_store;
              mem_addr_reg  <= req_base;
              mem_wstrb_reg <= req_store ? req_mask[7:0] : 8'h00;
              mem_wdata_reg <= req_store ? req_wide[63:0] : 64'h0;
            end
          end
        end
        S_BEAT0: begin
          if (mem_ready) begin
            if (store_reg && split) begin
              state_reg     <= S_BEAT1;
              mem_addr_reg  <= beat1_addr;
              mem_wstrb_reg <= mask_reg[15:8];
              mem_wdata_reg <= wide_reg[127:64];
            end else begin
              mem_valid_reg <= 1'b0;
              mem_we_reg    <= 1'b0;
              mem_wstrb_reg <= 8'h00;
              if (store_reg) begin
                state_reg      <= S_RESP;
                resp_valid_reg <= 1'b1;
                resp_rdata_reg <= '0;
              end else begin
                state_reg <= S_RWAIT0;
              end
            end
          end
        end
        S_RWAIT0: begin
          if (mem_rvalid) begin
            rdata0_reg <= mem_rdata;
            if (split) begin
              state_reg     <= S_BEAT1;
              mem_valid_reg <= 1'b1;
              mem_we_reg    <= 1'b0;
              mem_wstrb_reg <= 8'h00;
              mem_addr_reg  <= beat1_addr;
            end else begin
              state_reg      <= S_RESP;
              resp_valid_reg <= 1'b1;
              resp_rdata_reg <= load_extend({64'b0, mem_rdata}, off_reg, funct3_reg);
            end
          end
        end
        S_BEAT1: begin
          if (mem_ready) begin
            mem_valid_reg <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_wstrb_reg <= 8'h00;
            if (store_reg) begin
              state_reg      <= S_RESP;
              resp_valid_reg <= 1'b1;
              resp_rdata_reg <= '0;
            end else begin
              state_reg <= S_RWAIT1;
            end
          end
        end
        S_RWAIT1: begin
          if (mem_rvalid) begin
            state_reg      <= S_RESP;
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= load_extend({mem_rdata, rdata0_reg}, off_reg, funct3_reg);
          end
        end
        S_RESP: begin
          state_reg     <= S_IDLE;
          req_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= S_IDLE;
          req_ready_reg <= 1'b1;
          mem_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign mem_valid  = mem_valid_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mem_wstrb  = mem_wstrb_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array memory responder on the memory
// port and a byte-level reference model of loads and stores.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  load_store_unit #(.GPR_BITS(64), .ADDR_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [7:0] dut_mem [65536];
  logic [7:0] ref_mem [65536];

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } beat_t;
  beat_t       beat_q[$];
  logic [15:0] rd_q[$];

  int ready_mode  = 0;  // 0 random, 1 always ready, 2 never ready
  int rvalid_mode = 0;  // 0 random, 1 as soon as possible
  int stray_mode  = 0;  // 0 occasional, 1 every idle cycle

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  endtask

  function automatic logic [63:0] dut_dword(input logic [15:0] a);
    logic [63:0] d;
    for (int b = 0; b < 8; b++) d[8*b +: 8] = dut_mem[a + 16'(b)];
    return d;
  endfunction

  // Memory responder: all decisions made on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      rd_q.delete();
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end else begin
      if (rd_q.size() > 0 && (rvalid_mode == 1 || $urandom_range(0, 1) == 1)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = dut_dword(rd_q.pop_front());
      end else if (rd_q.size() == 0 && (stray_mode == 1 || (rvalid_mode == 0 && $urandom_range(0, 3) == 0))) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {$urandom, $urandom};
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom};
      end
      case (ready_mode)
        1:       mem_ready = 1'b1;
        2:       mem_ready = 1'b0;
        default: mem_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mem_valid && mem_ready) begin
        beat_q.push_back('{addr: mem_addr, we: mem_we, strb: mem_wstrb, wdata: mem_wdata});
        if (mem_we) begin
          for (int b = 0; b < 8; b++)
            if (mem_wstrb[b]) dut_mem[mem_addr + 16'(b)] = mem_wdata[8*b +: 8];
        end else begin
          rd_q.push_back(mem_addr);
        end
      end
    end
  end

  // Apply one request and check it against the byte-level model
  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, input int exp_lat);
    logic        legal;
    int          n;
    int          off;
    int          exp_nb;
    int          cycles;
    logic [15:0] a16;
    logic [15:0] exp_addr [2];
    logic [7:0]  exp_strb [2];
    logic [63:0] exp_val;
    int          nb;

    legal = !((f3 == 3'b111) || (st && f3[2]));
    n     = 1 << f3[1:0];
    a16   = addr[15:0];
    off   = int'(a16[2:0]);
    exp_nb = (off + n > 8) ? 2 : 1;
    exp_addr[0] = a16 & 16'hFFF8;
    exp_addr[1] = exp_addr[0] + 16'd8;
    exp_strb[0] = '0;
    exp_strb[1] = '0;
    exp_val = '0;
    for (int i = 0; i < n; i++) begin
      if (off + i < 8) exp_strb[0][off + i] = 1'b1;
      else             exp_strb[1][off + i - 8] = 1'b1;
      exp_val[8*i +: 8] = ref_mem[a16 + 16'(i)];
    end
    if (!f3[2] && n < 8 && exp_val[8*n-1])
      for (int i = 8*n; i < 64; i++) exp_val[i] = 1'b1;

    beat_q.delete();
    @(negedge clk);
    check_value("ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cycles = 1;
    check_value("ready_busy", req_ready, 0);
    while (!resp_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check_value("resp_seen", resp_valid, 1);
    if (!resp_valid) finish_run();
    if (exp_lat >= 0) check_value("latency", 64'(cycles), 64'(exp_lat));
    check_value("resp_err", resp_err, !legal);
    if (!legal) begin
      check_value("err_beats", 64'(beat_q.size()), 0);
    end else begin
      if (st) check_value("st_rdata", resp_rdata, 0);
      else    check_value("ld_rdata", resp_rdata, exp_val);
      check_value("beat_count", 64'(beat_q.size()), 64'(exp_nb));
      nb = (beat_q.size() < exp_nb) ? beat_q.size() : exp_nb;
      for (int k = 0; k < nb; k++) begin
        check_value("beat_addr", beat_q[k].addr, exp_addr[k]);
        check_value("beat_we", beat_q[k].we, st);
        check_value("beat_strb", beat_q[k].strb, st ? exp_strb[k] : 8'h00);
      end
      if (st) begin
        for (int i = 0; i < n; i++) ref_mem[a16 + 16'(i)] = wd[8*i +: 8];
        for (int i = 0; i < n; i++)
          check_value("st_byte", dut_mem[a16 + 16'(i)], ref_mem[a16 + 16'(i)]);
      end
    end
    $display("txn %s f3=%0d addr=0x%04h wdata=0x%016h -> err=%0d rdata=0x%016h beats=%0d cycles=%0d",
             st ? "ST" : "LD", f3, a16, wd, resp_err, resp_rdata, beat_q.size(), cycles);
    @(negedge clk);
    check_value("resp_pulse", resp_valid, 0);
    check_value("ready_back", req_ready, 1);
  endtask

  initial begin
    int          mism;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] ad;
    logic [63:0] wd;

    for (int i = 0; i < 65536; i++) begin
      dut_mem[i] = 8'($urandom);
      ref_mem[i] = dut_mem[i];
    end
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_value("rst_req_ready", req_ready, 1);
    check_value("rst_mem_valid", mem_valid, 0);
    check_value("rst_mem_we", mem_we, 0);
    check_value("rst_mem_wstrb", mem_wstrb, 0);
    check_value("rst_mem_addr", mem_addr, 0);
    check_value("rst_mem_wdata", mem_wdata, 0);
    check_value("rst_resp_valid", resp_valid, 0);
    check_value("rst_resp_err", resp_err, 0);
    check_value("rst_resp_rdata", resp_rdata, 0);
    rst = 1'b0;

    // Aligned SD, minimum latency
    ready_mode = 1; rvalid_mode = 1;
    do_txn(1'b1, 3'b011, 64'h0010, 64'h1122334455667788, 2);
    check_value("sd_wdata", beat_q[0].wdata, 64'h1122334455667788);

    // Aligned LD, minimum latency
    do_txn(1'b0, 3'b011, 64'h0010, 64'h0, 3);

    // Misaligned LW / LWU crossing a dword
    for (int b = 0; b < 8; b++) begin
      ref_mem[b]     = 8'(64'h8877665544332211 >> (8*b));
      ref_mem[8 + b] = 8'(64'h000000000000F099 >> (8*b));
      dut_mem[b]     = ref_mem[b];
      dut_mem[8 + b] = ref_mem[8 + b];
    end
    do_txn(1'b0, 3'b010, 64'h0006, 64'h0, -1);
    check_value("lw_split", resp_rdata, 64'hFFFFFFFFF0998877);
    do_txn(1'b0, 3'b110, 64'h0006, 64'h0, -1);
    check_value("lwu_split", resp_rdata, 64'h00000000F0998877);

    // Split SH
    do_txn(1'b1, 3'b001, 64'h0007, 64'hBEEF, 3);
    check_value("sh_lane0", beat_q[0].wdata[63:56], 8'hEF);
    check_value("sh_lane1", beat_q[1].wdata[7:0], 8'hBE);

    // SD wrapping at the top of the address space
    do_txn(1'b1, 3'b011, 64'hFFFC, 64'h0102030405060708, 3);
    do_txn(1'b0, 3'b011, 64'h0000_0000_0001_FFFC, 64'h0, -1);

    // Illegal encodings
    ready_mode = 0; rvalid_mode = 0;
    do_txn(1'b0, 3'b111, 64'h0020, 64'h0, 1);
    do_txn(1'b1, 3'b100, 64'h0021, 64'h55, 1);

    // Reset while a load is stuck in its first beat
    ready_mode = 2;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'h0040;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_value("ld_beat0_hold", mem_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_value("async_mem_valid", mem_valid, 0);
    check_value("async_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    stray_mode = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_value("stray_no_resp", resp_valid, 0);
      check_value("stray_no_beat", mem_valid, 0);
    end
    stray_mode = 0;

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (st && $urandom_range(0, 7) != 0) f3[2] = 1'b0;
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       ad = {$urandom, 16'($urandom), 16'($urandom_range(0, 63))};
        1:       ad = {$urandom, 16'($urandom), 16'($urandom_range(16'hFFF0, 16'hFFFF))};
        default: ad = {$urandom, $urandom};
      endcase
      do_txn(st, f3, ad, wd, -1);
    end

    mism = 0;
    for (int i = 0; i < 65536; i++) if (dut_mem[i] !== ref_mem[i]) mism++;
    check_value("mem_final", 64'(mism), 0);
    finish_run();
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
